// File: rtl/stream_xform_fifo.sv
// Elastic valid/ready byte stream buffer: each accepted beat is transformed
// (pass / rotl^key / invert / rotr) and queued in a DEPTH-entry FIFO.
module stream_xform_fifo #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter int               ROT   = 1,
  parameter logic [WIDTH-1:0] KEY   = WIDTH'(8'hA5),
  parameter int               CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           beat_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      2'b00:   r = d;
      2'b01:   r = ((d << ROT) | (d >> (WIDTH-ROT))) ^ KEY;
      2'b10:   r = ~d;
      default: r = (d >> ROT) | (d << (WIDTH-ROT));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready   = (level_q < LW'(DEPTH));
  assign out_valid  = (level_q != '0);
  // Gate on occupancy so the unreset storage never leaks out after reset.
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;
  assign beat_count = cnt_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = pop ? cnt_q + 1'b1 : cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= xform(in_data, mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_stream_xform_fifo.sv
// Scoreboard bench for stream_xform_fifo: queue reference model, negedge monitor,
// directed scenarios followed by a randomized phase.
module tb_stream_xform_fifo;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 16;
  localparam int LW = $clog2(D+1);

  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [LW-1:0] level;
  logic [CW-1:0] beat_count;

  stream_xform_fifo #(.WIDTH(W), .DEPTH(D), .ROT(1), .KEY(8'hA5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  logic [W-1:0] exp_q [$];
  int unsigned  mcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference transform, bit by bit from the rotation definition.
  function automatic logic [W-1:0] ref_xf(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    r = '0;
    case (m)
      2'd0: r = d;
      2'd1: begin
        for (int i = 0; i < W; i++) r[(i+1)%W] = d[i];
        r = r ^ 8'hA5;
      end
      2'd2: for (int i = 0; i < W; i++) r[i] = !d[i];
      default: for (int i = 0; i < W; i++) r[(i+W-1)%W] = d[i];
    endcase
    return r;
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
    mcnt = 0;
  end

  // Monitor: compare state against the queue model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit acc = in_valid && (exp_q.size() < D);
      automatic logic [W-1:0] e;
      chk("level", 32'(level), exp_q.size());
      chk("in_ready", 32'(in_ready), (exp_q.size() < D) ? 1 : 0);
      chk("out_valid", 32'(out_valid), (exp_q.size() != 0) ? 1 : 0);
      chk("beat_count", 32'(beat_count), int'(mcnt % (1 << CW)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_on_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
        end
        mcnt++;
      end
      if (flush) exp_q.delete();
      else if (acc) exp_q.push_back(ref_xf(in_data, mode));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] d);
    in_valid = v; mode = m; in_data = d;
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3*D && out_valid; i++) step();
    chk("drain_empty", 32'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  int base;

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_beat_count", 32'(beat_count), 0);
    step(); rst_n = 1'b1;
    step();

    // 1: single beat mode 01
    out_ready = 1'b1; drive(1'b1, 2'd1, 8'h3C);
    step(); in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data", 32'(out_data), 32'h DD);
    step();
    chk("t1_count", 32'(beat_count), 1);
    chk("t1_level", 32'(level), 0);

    // 2: back-to-back modes 00/10/11 while stalled
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 8'h3C); step();
    drive(1'b1, 2'd2, 8'h3C); step();
    drive(1'b1, 2'd3, 8'h3C); step();
    in_valid = 1'b0;
    chk("t2_level", 32'(level), 3);
    out_ready = 1'b1;
    chk("t2_d0", 32'(out_data), 32'h3C); step();
    chk("t2_d1", 32'(out_data), 32'hC3); step();
    chk("t2_d2", 32'(out_data), 32'h1E); step();
    out_ready = 1'b0;

    // 3: fill, refused 5th beat, one pop reopens
    for (int i = 0; i < D; i++) begin drive(1'b1, 2'd1, 8'h81); step(); end
    chk("t3_level", 32'(level), D);
    chk("t3_full", 32'(in_ready), 0);
    drive(1'b1, 2'd0, 8'h55); step();
    chk("t3_still_full", 32'(level), D);
    chk("t3_head", 32'(out_data), 32'hA6);
    in_valid = 1'b0; out_ready = 1'b1; step();
    out_ready = 1'b0;
    chk("t3_reopen", 32'(in_ready), 1);
    drain();

    // 4: steady stream at level 1
    drive(1'b1, 2'd0, 8'h10); step();
    base = int'(beat_count);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'($urandom_range(3)), 8'($urandom)); step();
      chk("t4_level", 32'(level), 1);
    end
    chk("t4_count", 32'(beat_count), (base + 20) % (1 << CW));
    drain();

    // 5: flush while pushing and popping
    for (int i = 0; i < 3; i++) begin drive(1'b1, 2'd2, 8'(i)); step(); end
    base = int'(beat_count);
    flush = 1'b1; out_ready = 1'b1; drive(1'b1, 2'd0, 8'h77); step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_level", 32'(level), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_count", 32'(beat_count), (base + 1) % (1 << CW));
    step();
    chk("t5_absent", 32'(out_valid), 0);
    out_ready = 1'b0;

    // 6: asynchronous reset between edges
    for (int i = 0; i < 2; i++) begin drive(1'b1, 2'd1, 8'h5A); step(); end
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_level", 32'(level), 0);
    chk("t6_count", 32'(beat_count), 0);
    chk("t6_data", 32'(out_data), 0);
    step(); rst_n = 1'b1;
    drive(1'b1, 2'd2, 8'h00); step(); in_valid = 1'b0;
    chk("t6_inv", 32'(out_data), 32'hFF);
    drain();

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom));
      out_ready = 1'($urandom_range(2) != 0);
      flush = ($urandom_range(24) == 0);
      step();
    end
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
